// File: rtl/unmix_hash.sv
// unmix_hash: multi-cycle inverse of the mix_hash 32-bit integer mix, one inverse step per clock.
// Optional self-check of the recovered key against the forward mix: UNMIX_HASH_SELFCHECK_EN.
module unmix_hash (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] num,
   output logic        busy,
   output logic        done,
   output logic [31:0] out
`ifdef UNMIX_HASH_SELFCHECK_EN
   ,
   output logic        mismatch
`endif
);

   // Handshake: start/num are accepted on a rising edge only in IDLE or DONE; during
   // S1..S6 start is ignored (dropped, not queued). done is high exactly while in DONE,
   // and out holds the recovered key for as long as done stays high.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      S4   = 3'd4,
      S5   = 3'd5,
      S6   = 3'd6,
      DONE = 3'd7
   } state_t;

   state_t      state, state_next;
   logic [31:0] key, key_next;
   logic [31:0] step;
   logic [31:0] z;
   logic        accept;

   assign accept = start && ((state == IDLE) || (state == DONE));

   // Inverse steps, applied in reverse order of the forward mix.
   always_comb begin
      z    = key + 32'd1;
      step = key;
      case (state)
         S1:      step = key ^ (key >> 16);
         S2:      step = z + (z << 11) + (z << 22);
         S3:      step = key ^ (key >> 6) ^ (key >> 12) ^ (key >> 18) ^ (key >> 24) ^ (key >> 30);
         S4:      step = key * 32'h38E38E39;
         S5:      step = key ^ (key >> 15) ^ (key >> 30);
         S6:      step = z + (z << 15) + (z << 30);
         default: step = key;
      endcase
   end

   always_comb begin
      state_next = state;
      key_next   = key;
      if (accept) begin
         state_next = S1;
         key_next   = num;
      end else if ((state != IDLE) && (state != DONE)) begin
         state_next = state_t'(state + 3'd1);
         key_next   = step;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         key   <= 32'h0;
      end else begin
         state <= state_next;
         key   <= key_next;
      end
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);
   assign out  = key;

`ifdef UNMIX_HASH_SELFCHECK_EN
   logic [31:0] chk;

   function automatic logic [31:0] mix_fwd(input logic [31:0] v);
      logic [31:0] x;
      x = v - (v << 15) - 32'd1;
      x = x ^ (x >> 15);
      x = x + (x << 3);
      x = x ^ (x >> 6);
      x = x - (x << 11) - 32'd1;
      x = x ^ (x >> 16);
      return x;
   endfunction

   // The flag is judged from the S6 result so it is valid in the same cycle done rises.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chk      <= 32'h0;
         mismatch <= 1'b0;
      end else if (accept) begin
         chk      <= num;
         mismatch <= 1'b0;
      end else if (state == S6) begin
         mismatch <= (mix_fwd(step) != chk);
      end
   end
`endif

endmodule

// File: tb/tb_unmix_hash.sv
// Directed bench for unmix_hash: reset, known vector, busy-ignore, back-to-back,
// mid-run reset, idle stability and a random round trip through a forward-mix model.
module tb_unmix_hash;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] num;
   logic        busy;
   logic        done;
   logic [31:0] out;
`ifdef UNMIX_HASH_SELFCHECK_EN
   logic        mismatch;
`endif

   int n_vec;
   int n_err;
   logic [31:0] exp_q[$];

   unmix_hash dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .num      (num),
      .busy     (busy),
      .done     (done),
      .out      (out)
`ifdef UNMIX_HASH_SELFCHECK_EN
      ,
      .mismatch (mismatch)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mix(input logic [31:0] v);
      logic [31:0] x;
      x = v - (v << 15) - 32'd1;
      x = x ^ (x >> 15);
      x = x * 32'd9;
      x = x ^ (x >> 6);
      x = x - (x << 11) - 32'd1;
      x = x ^ (x >> 16);
      return x;
   endfunction

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      num   = 32'h0;
      tick(2);
      n_vec++;
      if (out !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0); end
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef UNMIX_HASH_SELFCHECK_EN
      n_vec++;
      if (mismatch !== 1'b0) begin n_err++; $display("FAIL reset_mismatch got=%b exp=0", mismatch); end
`endif
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_known_vector;
      start = 1'b1;
      num   = 32'h6E51D9AE;
      tick(1);  // E0
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL known_busy_e0 got=%b exp=1", busy); end
      tick(4);  // E4
      tick(1);  // E5
      n_vec++;
      if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL known_e5 busy,done got=%b exp=10", {busy, done}); end
      tick(1);  // E6
      n_vec++;
      if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL known_e6 busy,done got=%b exp=01", {busy, done}); end
      n_vec++;
      if (out !== 32'h00000000) begin n_err++; $display("FAIL known_out got=%h exp=%h", out, 32'h0); end
`ifdef UNMIX_HASH_SELFCHECK_EN
      n_vec++;
      if (mismatch !== 1'b0) begin n_err++; $display("FAIL known_mismatch got=%b exp=0", mismatch); end
`endif
   endtask

   task automatic test_busy_ignore;
      start = 1'b1;
      num   = 32'h6E51D9AE;
      tick(1);  // E0
      start = 1'b0;
      tick(1);  // E1
      start = 1'b1;
      num   = 32'h12345678;
      tick(1);  // E2: must be ignored
      start = 1'b0;
      tick(4);  // E6
      n_vec++;
      if (done !== 1'b1) begin n_err++; $display("FAIL ignore_done got=%b exp=1", done); end
      n_vec++;
      if (out !== 32'h00000000) begin n_err++; $display("FAIL ignore_out got=%h exp=%h", out, 32'h0); end
      tick(3);
      n_vec++;
      if ({busy, done, out} !== {1'b0, 1'b1, 32'h0}) begin
         n_err++; $display("FAIL ignore_dropped busy,done,out got=%b%b %h exp=01 00000000", busy, done, out);
      end
   endtask

   task automatic test_back_to_back;
      int lows;
      start = 1'b1;
      num   = 32'h6E51D9AE;
      tick(1);  // accepted from DONE
      num   = mix(32'hDEADBEEF);
      tick(5);
      tick(1);
      n_vec++;
      if ({done, out} !== {1'b1, 32'h0}) begin
         n_err++; $display("FAIL b2b_first done,out got=%b %h exp=1 00000000", done, out);
      end
      lows = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (done === 1'b0) lows++;
      end
      n_vec++;
      if (lows !== 6) begin n_err++; $display("FAIL b2b_done_low_cycles got=%0d exp=6", lows); end
      tick(1);  // 7 cycles after first result
      start = 1'b0;
      n_vec++;
      if ({done, out} !== {1'b1, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL b2b_second done,out got=%b %h exp=1 deadbeef", done, out);
      end
      tick(1);
      n_vec++;
      if ({done, out} !== {1'b1, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL b2b_hold done,out got=%b %h exp=1 deadbeef", done, out);
      end
   endtask

   task automatic test_reset_mid_run;
      start = 1'b1;
      num   = 32'h13579BDF;
      tick(1);  // E0
      start = 1'b0;
      tick(3);  // E3
      reset = 1'b1;
      #1;
      n_vec++;
      if ({out, done, busy} !== {32'h0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL midreset out,done,busy got=%h %b%b exp=00000000 00", out, done, busy);
      end
      tick(1);
      reset = 1'b0;
      tick(1);
      start = 1'b1;
      num   = mix(32'hCAFEF00D);
      tick(1);
      start = 1'b0;
      tick(6);
      n_vec++;
      if ({done, out} !== {1'b1, 32'hCAFEF00D}) begin
         n_err++; $display("FAIL midreset_next done,out got=%b %h exp=1 cafef00d", done, out);
      end
   endtask

   task automatic test_idle_stability;
      logic [31:0] held;
      int          bad;
      held = out;
      bad  = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if ((out !== 32'hCAFEF00D) || (done !== 1'b1)) bad++;
      end
      n_vec++;
      if (bad !== 0) begin n_err++; $display("FAIL idle_stable bad_cycles=%0d out=%h exp=cafef00d held=%h", bad, out, held); end
   endtask

   task automatic test_round_trip;
      logic [31:0] v;
      logic [31:0] expv;
      int          bad;
      int          mm;
      bad = 0;
      mm  = 0;
      for (int i = 0; i < 10000; i++) begin
         v = $urandom;
         if (i == 0) v = 32'hFFFFFFFF;
         if (i == 1) v = 32'h00000001;
         exp_q.push_back(v);
         start = 1'b1;
         num   = mix(v);
         tick(1);
         start = 1'b0;
         tick(6);
         expv = exp_q.pop_front();
         if ((done !== 1'b1) || (out !== expv)) begin
            bad++;
            if (bad <= 5) $display("FAIL round_trip num=%h got=%h exp=%h done=%b", mix(expv), out, expv, done);
         end
`ifdef UNMIX_HASH_SELFCHECK_EN
         if (mismatch !== 1'b0) mm++;
`endif
      end
      n_vec++;
      if (bad !== 0) begin n_err++; $display("FAIL round_trip_total bad=%0d exp=0", bad); end
`ifdef UNMIX_HASH_SELFCHECK_EN
      n_vec++;
      if (mm !== 0) begin n_err++; $display("FAIL round_trip_mismatch count=%0d exp=0", mm); end
`endif
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      start = 1'b0;
      num   = 32'h0;
      test_reset;
      test_known_vector;
      test_busy_ignore;
      test_back_to_back;
      test_reset_mid_run;
      test_idle_stability;
      test_round_trip;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
